pps_generator: RTL

PPS_GENERATOR -- requirements
Module: pps_generator

---
 rtl/pps_pkg.sv | 22 ++
 rtl/pps_generator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pps_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pps_pkg
// Purpose  : Shared definitions for the PPS transmit and receive paths:
//            generator state encoding and configuration validity limits.
// Revision : 1.0 - initial release
// ============================================================================
package pps_pkg;

    // Generator run state. One bit is enough for the two states.
    typedef enum logic [0:0] {
        PPS_IDLE = 1'b0,
        PPS_RUN  = 1'b1
    } pps_state_e;

    // A configuration is accepted only if period >= c_MIN_PERIOD,
    // high >= c_MIN_HIGH and high < period.
    localparam int unsigned c_MIN_PERIOD = 2;
    localparam int unsigned c_MIN_HIGH   = 1;

endpackage : pps_pkg
`default_nettype wire

// File: rtl/pps_generator.sv
`default_nettype none
// ============================================================================
// Module   : pps_generator
// Purpose  : Programmable pulse-per-second generator. A phase counter runs
//            over an active period; pps_out is high while phase < active
//            high time. New configurations are shadowed while running and
//            take effect at the next period boundary (wrap or align).
// Ports    : clk        - timebase clock, all logic on rising edge
//            rst_n      - asynchronous active-low reset
//            enable     - level, high runs the generator
//            align_in   - strobe that restarts the second boundary
//            cfg_valid  - configuration offered
//            cfg_period - requested period in clk cycles
//            cfg_high   - requested high time in clk cycles
//            cfg_ready  - configuration can be accepted
//            cfg_err    - one-cycle pulse on a rejected configuration
//            pps_out    - generated pulse
//            pps_count  - toggles on every pps_out rising edge
//            phase      - current position within the period
// Revision : 1.0 - initial release
// ============================================================================
module pps_generator
    import pps_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DEFAULT_PERIOD = 10000000,
    parameter int unsigned DEFAULT_HIGH   = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             align_in,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             pps_out,
    output logic             pps_count,
    output logic [WIDTH-1:0] phase
);

    localparam logic [WIDTH-1:0] c_MIN_PERIOD_W = WIDTH'(c_MIN_PERIOD);
    localparam logic [WIDTH-1:0] c_MIN_HIGH_W   = WIDTH'(c_MIN_HIGH);
    localparam logic [WIDTH-1:0] c_DEF_PERIOD   = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] c_DEF_HIGH     = WIDTH'(DEFAULT_HIGH);

    // Registered state
    pps_state_e       r_state;
    logic [WIDTH-1:0] r_phase;
    logic             r_pps_out;
    logic             r_pps_count;
    logic             r_cfg_ready;
    logic             r_cfg_err;
    logic [WIDTH-1:0] r_active_period;
    logic [WIDTH-1:0] r_active_high;
    logic             r_pend_valid;
    logic [WIDTH-1:0] r_pend_period;
    logic [WIDTH-1:0] r_pend_high;

    // Next-state values
    pps_state_e       w_state_next;
    logic [WIDTH-1:0] w_phase_next;
    logic             w_pps_next;
    logic             w_cfg_ready_next;
    logic [WIDTH-1:0] w_active_period_next;
    logic [WIDTH-1:0] w_active_high_next;
    logic             w_pend_valid_next;
    logic [WIDTH-1:0] w_pend_period_next;
    logic [WIDTH-1:0] w_pend_high_next;

    logic             w_xfer;
    logic             w_cfg_ok;
    logic             w_wrap;
    logic [WIDTH-1:0] w_phase_inc;

    assign w_xfer      = cfg_valid & r_cfg_ready;
    assign w_cfg_ok    = (cfg_period >= c_MIN_PERIOD_W) &&
                         (cfg_high >= c_MIN_HIGH_W) &&
                         (cfg_high < cfg_period);
    // >= rather than == keeps the counter bounded even if phase were ever
    // beyond the period; configurations only change at phase 0 while running.
    assign w_wrap      = (r_phase >= (r_active_period - 1'b1));
    assign w_phase_inc = r_phase + 1'b1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= PPS_IDLE;
            r_phase         <= '0;
            r_pps_out       <= 1'b0;
            r_pps_count     <= 1'b0;
            r_cfg_ready     <= 1'b1;
            r_cfg_err       <= 1'b0;
            r_active_period <= c_DEF_PERIOD;
            r_active_high   <= c_DEF_HIGH;
            r_pend_valid    <= 1'b0;
            r_pend_period   <= '0;
            r_pend_high     <= '0;
        end else begin
            r_state         <= w_state_next;
            r_phase         <= w_phase_next;
            r_pps_out       <= w_pps_next;
            // Toggle exactly when the output is about to rise.
            r_pps_count     <= r_pps_count ^ (w_pps_next & ~r_pps_out);
            r_cfg_ready     <= w_cfg_ready_next;
            r_cfg_err       <= w_xfer & ~w_cfg_ok;
            r_active_period <= w_active_period_next;
            r_active_high   <= w_active_high_next;
            r_pend_valid    <= w_pend_valid_next;
            r_pend_period   <= w_pend_period_next;
            r_pend_high     <= w_pend_high_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next         = r_state;
        w_phase_next         = r_phase;
        w_pps_next           = r_pps_out;
        w_cfg_ready_next     = r_cfg_ready;
        w_active_period_next = r_active_period;
        w_active_high_next   = r_active_high;
        w_pend_valid_next    = r_pend_valid;
        w_pend_period_next   = r_pend_period;
        w_pend_high_next     = r_pend_high;

        case (r_state)
            PPS_IDLE: begin
                w_phase_next = '0;
                w_pps_next   = 1'b0;
                // Nothing is running, so a good configuration goes live now.
                if (w_xfer && w_cfg_ok) begin
                    w_active_period_next = cfg_period;
                    w_active_high_next   = cfg_high;
                end
                if (enable) begin
                    w_state_next = PPS_RUN;
                    w_pps_next   = 1'b1;
                end
            end

            PPS_RUN: begin
                if (!enable) begin
                    // Disable wins over align; any shadowed or just-offered
                    // configuration is dropped along with the run.
                    w_state_next      = PPS_IDLE;
                    w_phase_next      = '0;
                    w_pps_next        = 1'b0;
                    w_pend_valid_next = 1'b0;
                    w_cfg_ready_next  = 1'b1;
                end else begin
                    if (align_in || w_wrap) begin
                        w_phase_next = '0;
                        w_pps_next   = 1'b1;
                        if (r_pend_valid) begin
                            w_active_period_next = r_pend_period;
                            w_active_high_next   = r_pend_high;
                            w_pend_valid_next    = 1'b0;
                            w_cfg_ready_next     = 1'b1;
                        end
                    end else begin
                        w_phase_next = w_phase_inc;
                        w_pps_next   = (w_phase_inc < r_active_high);
                    end
                    // A transfer on a boundary cycle is shadowed and waits for
                    // the following boundary. cfg_ready was high, so no older
                    // pending value can be present here.
                    if (w_xfer && w_cfg_ok) begin
                        w_pend_valid_next  = 1'b1;
                        w_pend_period_next = cfg_period;
                        w_pend_high_next   = cfg_high;
                        w_cfg_ready_next   = 1'b0;
                    end
                end
            end

            default: begin
                w_state_next = PPS_IDLE;
            end
        endcase
    end

    assign phase     = r_phase;
    assign pps_out   = r_pps_out;
    assign pps_count = r_pps_count;
    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;

endmodule : pps_generator
`default_nettype wire
